uart_tx_param: RTL



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_bit_timer.sv | 46 ++++
 rtl/uart_tx_param.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions used by the transmitter and receiver:
//            FSM state encoding, default frame geometry, and parity modes.
// Ports    : none (package)
// Config   : UART_TX_PARITY_EN enables the PARITY state in the transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_t;

  localparam int c_default_data_w     = 8;
  localparam int c_default_oversample = 4;

  localparam logic c_parity_even = 1'b0;
  localparam logic c_parity_odd  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_bit_timer
// Purpose  : Counts baud Tick strobes and flags the last Tick of each bit
//            period (OVERSAMPLE Ticks per bit).
// Ports    : Clk     - system clock
//            Rst     - synchronous active-high reset
//            clear   - hold the count at zero; Ticks are ignored while high
//            Tick    - single-cycle baud enable strobe
//            bit_end - high on the Tick that completes a bit period
// Config   : UART_TX_PARITY_EN (not used in this module)
// Revision : 1.0 - initial release
// ============================================================================
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = c_default_oversample
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic Tick,
  output logic bit_end
);

  // Keep at least one counter bit so OVERSAMPLE=1 still elaborates.
  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last  = (r_cnt == c_last);
  // A Tick landing while clear is high (e.g. the accept cycle) never counts.
  assign bit_end = Tick & ~clear & w_last;

  always_ff @(posedge Clk) begin
    if (Rst || clear) begin
      r_cnt <= '0;
    end else if (Tick) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_param
// Purpose  : Parametrised UART transmitter. One frame per TxValid/TxReady
//            handshake: start bit, 1..DATA_W data bits LSB-first, optional
//            parity bit, then 1 or 2 stop bits; each bit lasts OVERSAMPLE
//            Tick strobes.
// Ports    : Clk, Rst            - clock, synchronous active-high reset
//            Tick                - baud enable strobe
//            TxValid / TxReady   - frame request / accept handshake
//            TxData, NBits       - payload and bit count (0 or >DATA_W = DATA_W)
//            StopBits2           - 0: one stop bit, 1: two stop bits
//            ParityEn, ParityOdd - parity enable / odd select (macro only)
//            Tx                  - registered serial output, idle high
//            TxBusy              - frame in progress
//            TxDone              - one-cycle pulse at frame end
// Config   : define UART_TX_PARITY_EN to add the parity ports and state.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W     = c_default_data_w,
  parameter int OVERSAMPLE = c_default_oversample,
  parameter int NB_W       = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Tick,
  input  logic              TxValid,
  output logic              TxReady,
  input  logic [DATA_W-1:0] TxData,
  input  logic [NB_W-1:0]   NBits,
  input  logic              StopBits2,
`ifdef UART_TX_PARITY_EN
  input  logic              ParityEn,
  input  logic              ParityOdd,
`endif
  output logic              Tx,
  output logic              TxBusy,
  output logic              TxDone
);

  localparam logic [NB_W-1:0] c_data_w_nb = NB_W'(DATA_W);

  uart_state_t       r_state,    n_state;
  logic [DATA_W-1:0] r_shift,    n_shift;
  logic [NB_W-1:0]   r_bit_idx,  n_bit_idx;
  logic [NB_W-1:0]   r_last_idx, n_last_idx;
  logic              r_stop2,    n_stop2;   // second stop bit still pending
  logic              r_tx,       n_tx;
  logic              r_done,     n_done;

  logic              w_accept;
  logic              w_bit_end;
  logic [NB_W-1:0]   w_nbits_eff;
  logic              w_par_en;
  logic              w_par_tx;

`ifdef UART_TX_PARITY_EN
  logic r_par_en,  n_par_en;
  logic r_par_odd, n_par_odd;
  logic r_parity,  n_parity;   // running XOR of data bits already sent
  assign w_par_en = r_par_en;
  assign w_par_tx = n_parity ^ r_par_odd;
`else
  assign w_par_en = 1'b0;
  assign w_par_tx = 1'b1;
`endif

  assign w_accept    = TxValid && (r_state == S_IDLE);
  assign w_nbits_eff = ((NBits == '0) || (NBits > c_data_w_nb)) ? c_data_w_nb : NBits;

  // Timer is held cleared in IDLE so the first counted Tick is the one after
  // accept, and a Tick coincident with accept is dropped.
  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .Clk     (Clk),
    .Rst     (Rst),
    .clear   (r_state == S_IDLE),
    .Tick    (Tick),
    .bit_end (w_bit_end)
  );

  always_comb begin
    n_state    = r_state;
    n_shift    = r_shift;
    n_bit_idx  = r_bit_idx;
    n_last_idx = r_last_idx;
    n_stop2    = r_stop2;
    n_done     = 1'b0;
`ifdef UART_TX_PARITY_EN
    n_par_en   = r_par_en;
    n_par_odd  = r_par_odd;
    n_parity   = r_parity;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          n_state    = S_START;
          n_shift    = TxData;
          n_bit_idx  = '0;
          n_last_idx = w_nbits_eff - 1'b1;
          n_stop2    = StopBits2;
`ifdef UART_TX_PARITY_EN
          n_par_en   = ParityEn;
          n_par_odd  = ParityOdd;
          n_parity   = 1'b0;
`endif
        end
      end
      S_START: begin
        if (w_bit_end) n_state = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
`ifdef UART_TX_PARITY_EN
          n_parity = r_parity ^ r_shift[0];
`endif
          if (r_bit_idx == r_last_idx) begin
            n_state = w_par_en ? S_PARITY : S_STOP;
          end else begin
            n_shift   = r_shift >> 1;
            n_bit_idx = r_bit_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) n_state = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_stop2) begin
            n_stop2 = 1'b0;
          end else begin
            n_state = S_IDLE;
            n_done  = 1'b1;
          end
        end
      end
      default: n_state = S_IDLE;
    endcase

    // Line level follows the state being entered so Tx is a clean register.
    case (n_state)
      S_START:  n_tx = 1'b0;
      S_DATA:   n_tx = n_shift[0];
      S_PARITY: n_tx = w_par_tx;
      default:  n_tx = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_last_idx <= '0;
      r_stop2    <= 1'b0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= n_state;
      r_shift    <= n_shift;
      r_bit_idx  <= n_bit_idx;
      r_last_idx <= n_last_idx;
      r_stop2    <= n_stop2;
      r_tx       <= n_tx;
      r_done     <= n_done;
`ifdef UART_TX_PARITY_EN
      r_par_en   <= n_par_en;
      r_par_odd  <= n_par_odd;
      r_parity   <= n_parity;
`endif
    end
  end

  assign Tx      = r_tx;
  assign TxDone  = r_done;
  assign TxReady = (r_state == S_IDLE);
  assign TxBusy  = (r_state != S_IDLE);

endmodule
`default_nettype wire
